// File: rtl/complete_arbiter_pkg.sv
// rtl/complete_arbiter_pkg.sv - shared completion packet type, default sizes and a saturating-add helper
package complete_arbiter_pkg;
    localparam int XLEN            = 32;
    localparam int NUM_FU_COMPLETE = 4;
    localparam int DEF_CDB_WIDTH   = 2;
    localparam int DEF_ROB_SIZE    = 32;
    localparam int ROB_IDX_W       = $clog2(DEF_ROB_SIZE);
    localparam int PRF_IDX_W       = 6;

    typedef struct packed {
        logic                 valid;
        logic [PRF_IDX_W-1:0] dest_pr;
        logic [XLEN-1:0]      dest_value;
        logic [ROB_IDX_W-1:0] rob_entry;
        logic                 if_take_branch;
        logic [XLEN-1:0]      target_pc;
        logic                 halt;
    } fu_complete_packet_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction
endpackage

// File: rtl/complete_arbiter_rr_multi_grant.sv
// rtl/complete_arbiter_rr_multi_grant.sv - combinational round-robin scan granting up to CDB_WIDTH requesters
module rr_multi_grant #(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int LW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1
) (
    input  logic [PW-1:0]              ptr,
    input  logic [NUM_FU-1:0]          req,
    output logic [NUM_FU-1:0]          grant,
    output logic [NUM_FU-1:0][LW-1:0]  lane,
    output logic [PW-1:0]              next_ptr
);
    always_comb begin
        int cnt;
        int idx;
        grant    = '0;
        lane     = '0;
        next_ptr = ptr;
        cnt      = 0;
        idx      = 0;
        for (int s = 0; s < NUM_FU; s++) begin
            idx = (int'(ptr) + s) % NUM_FU;
            if (req[PW'(idx)] && cnt < CDB_WIDTH) begin
                grant[PW'(idx)] = 1'b1;
                lane[PW'(idx)]  = LW'(cnt);
                cnt             = cnt + 1;
                // pointer lands just past the last FU granted in scan order
                next_ptr        = PW'((idx + 1) % NUM_FU);
            end
        end
    end
endmodule

// File: rtl/complete_arbiter.sv
// rtl/complete_arbiter.sv - FU completion arbiter onto CDB lanes with branch recovery; perf counters under COMPLETE_PERF_EN
module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int NUM_FU    = NUM_FU_COMPLETE,
    parameter int CDB_WIDTH = DEF_CDB_WIDTH,
    parameter int ROB_SIZE  = DEF_ROB_SIZE,
    localparam int RW = $clog2(ROB_SIZE),
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int LW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic [RW-1:0]       rob_head,
    input  logic [NUM_FU-1:0]   want_to_complete,
    input  fu_complete_packet_t fu_packet_in [NUM_FU],
    output logic [NUM_FU-1:0]   complete_stall,
    output fu_complete_packet_t cdb_packet_out [CDB_WIDTH],
    output logic                br_recover_valid,
    output logic [XLEN-1:0]     br_recover_pc,
    output logic [RW-1:0]       br_recover_rob
`ifdef COMPLETE_PERF_EN
    ,
    output logic [31:0]         perf_grant_cnt,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_br_recover_cnt
`endif
);
    logic [NUM_FU-1:0]         req;
    logic [NUM_FU-1:0]         grant;
    logic [NUM_FU-1:0][LW-1:0] lane_of;
    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             next_ptr;
    fu_complete_packet_t       lane_pkt [CDB_WIDTH];
    logic                      br_sel_valid;
    logic [RW-1:0]             br_sel_age;
    logic [RW-1:0]             br_sel_rob;
    logic [XLEN-1:0]           br_sel_pc;
    logic [RW-1:0]             age;

    // reset and squash suppress every request, which also zeroes the stalls
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_FU; i++)
            req[i] = want_to_complete[i] && fu_packet_in[i].valid && !reset && !squash;
    end

    rr_multi_grant #(.NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH)) u_scan (
        .ptr      (rr_ptr),
        .req      (req),
        .grant    (grant),
        .lane     (lane_of),
        .next_ptr (next_ptr)
    );

    assign complete_stall = req & ~grant;

    always_comb begin
        for (int k = 0; k < CDB_WIDTH; k++)
            lane_pkt[k] = '0;
        for (int i = 0; i < NUM_FU; i++)
            if (grant[i])
                lane_pkt[lane_of[i]] = fu_packet_in[i];
    end

    // oldest taken branch: smallest distance from the ROB head, modulo ROB size
    always_comb begin
        br_sel_valid = 1'b0;
        br_sel_age   = '0;
        br_sel_rob   = '0;
        br_sel_pc    = '0;
        age          = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i] && fu_packet_in[i].if_take_branch) begin
                age = RW'(fu_packet_in[i].rob_entry) - rob_head;
                if (!br_sel_valid || age < br_sel_age) begin
                    br_sel_valid = 1'b1;
                    br_sel_age   = age;
                    br_sel_rob   = RW'(fu_packet_in[i].rob_entry);
                    br_sel_pc    = fu_packet_in[i].target_pc;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr           <= '0;
            br_recover_valid <= 1'b0;
            br_recover_pc    <= '0;
            br_recover_rob   <= '0;
            for (int k = 0; k < CDB_WIDTH; k++)
                cdb_packet_out[k] <= '0;
        end else begin
            rr_ptr           <= next_ptr;
            br_recover_valid <= br_sel_valid;
            if (br_sel_valid) begin
                br_recover_pc  <= br_sel_pc;
                br_recover_rob <= br_sel_rob;
            end
            for (int k = 0; k < CDB_WIDTH; k++)
                cdb_packet_out[k] <= lane_pkt[k];
        end
    end

`ifdef COMPLETE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grant_cnt      <= '0;
            perf_stall_cnt      <= '0;
            perf_br_recover_cnt <= '0;
        end else begin
            perf_grant_cnt      <= sat_add(perf_grant_cnt, 32'($countones(grant)));
            perf_stall_cnt      <= sat_add(perf_stall_cnt, {31'd0, |complete_stall});
            perf_br_recover_cnt <= sat_add(perf_br_recover_cnt, {31'd0, br_sel_valid});
        end
    end
`endif
endmodule

// File: tb/tb_complete_arbiter.sv
// tb/tb_complete_arbiter.sv - self-checking bench: hand sequences, vector table and randomized model comparison
module tb_complete_arbiter;
    import complete_arbiter_pkg::*;

    localparam int NF = 4;
    localparam int CW = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic                squash;
    logic [4:0]          rob_head;
    logic [NF-1:0]       want_to_complete;
    fu_complete_packet_t fu_packet_in [NF];
    logic [NF-1:0]       complete_stall;
    fu_complete_packet_t cdb_packet_out [CW];
    logic                br_recover_valid;
    logic [XLEN-1:0]     br_recover_pc;
    logic [4:0]          br_recover_rob;
`ifdef COMPLETE_PERF_EN
    logic [31:0]         perf_grant_cnt, perf_stall_cnt, perf_br_recover_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    complete_arbiter #(.NUM_FU(NF), .CDB_WIDTH(CW), .ROB_SIZE(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .squash           (squash),
        .rob_head         (rob_head),
        .want_to_complete (want_to_complete),
        .fu_packet_in     (fu_packet_in),
        .complete_stall   (complete_stall),
        .cdb_packet_out   (cdb_packet_out),
        .br_recover_valid (br_recover_valid),
        .br_recover_pc    (br_recover_pc),
        .br_recover_rob   (br_recover_rob)
`ifdef COMPLETE_PERF_EN
        ,
        .perf_grant_cnt      (perf_grant_cnt),
        .perf_stall_cnt      (perf_stall_cnt),
        .perf_br_recover_cnt (perf_br_recover_cnt)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic fu_complete_packet_t pk(input int i);
        fu_complete_packet_t p;
        p            = '0;
        p.valid      = 1'b1;
        p.dest_pr    = PRF_IDX_W'(8 + i);
        p.dest_value = 32'(100 + i);
        p.rob_entry  = ROB_IDX_W'(i);
        p.halt       = (i == 2);
        return p;
    endfunction

    task automatic set_fus();
        for (int i = 0; i < NF; i++) fu_packet_in[i] = pk(i);
    endtask

    task automatic do_reset();
        reset = 1'b1; squash = 1'b0; want_to_complete = '0;
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       sq;
        logic [3:0] stall;
        int         src0;
        int         src1;
        int         ptr;
    } vec_t;
    vec_t vt [10];

    fu_complete_packet_t mp [NF];
    logic [NF-1:0] hold, w, gmask, exp_stall;
    logic          sq_r;
    int            g [$];
    int            m_ptr, next_rob, best_age, a;
    logic          best_v;
    logic [31:0]   m_pc;
    logic [4:0]    m_rob;

    initial begin
        reset = 1'b1; squash = 1'b0; rob_head = '0; want_to_complete = '0;
        for (int i = 0; i < NF; i++) fu_packet_in[i] = '0;
        cyc(); cyc();
        #1 chk("reset_stall", 128'(complete_stall), 128'(4'b0000));
        chk("reset_lane0", 128'(cdb_packet_out[0]), 128'(0));
        chk("reset_lane1", 128'(cdb_packet_out[1]), 128'(0));
        chk("reset_br", 128'({br_recover_valid, br_recover_pc, br_recover_rob}), 128'(0));
        chk("reset_ptr", 128'(dut.rr_ptr), 128'(0));
        reset = 1'b0;

        // single request from FU0
        fu_packet_in[0] = '0; fu_packet_in[0].valid = 1'b1;
        fu_packet_in[0].dest_pr = 6'd32; fu_packet_in[0].dest_value = 32'd144;
        want_to_complete = 4'b0001;
        #1 chk("single_stall", 128'(complete_stall), 128'(4'b0000));
        cyc();
        chk("single_valid", 128'(cdb_packet_out[0].valid), 128'(1));
        chk("single_pr", 128'(cdb_packet_out[0].dest_pr), 128'(32));
        chk("single_val", 128'(cdb_packet_out[0].dest_value), 128'(144));
        chk("single_l1", 128'(cdb_packet_out[1].valid), 128'(0));
        chk("single_ptr", 128'(dut.rr_ptr), 128'(1));

        // all four request; granted ones drop out next cycle
        do_reset(); set_fus(); want_to_complete = 4'b1111;
        #1 chk("all1_stall", 128'(complete_stall), 128'(4'b1100));
        cyc();
        chk("all1_l0", 128'(cdb_packet_out[0]), 128'(pk(0)));
        chk("all1_l1", 128'(cdb_packet_out[1]), 128'(pk(1)));
        want_to_complete = 4'b1100;
        #1 chk("all2_stall", 128'(complete_stall), 128'(4'b0000));
        cyc();
        chk("all2_l0", 128'(cdb_packet_out[0]), 128'(pk(2)));
        chk("all2_l1", 128'(cdb_packet_out[1]), 128'(pk(3)));
        chk("all2_ptr", 128'(dut.rr_ptr), 128'(0));

        // wrap from FU3 to FU0
        want_to_complete = 4'b0100; cyc();
        chk("wrap_pre_ptr", 128'(dut.rr_ptr), 128'(3));
        want_to_complete = 4'b1001; cyc();
        chk("wrap_l0", 128'(cdb_packet_out[0]), 128'(pk(3)));
        chk("wrap_l1", 128'(cdb_packet_out[1]), 128'(pk(0)));
        chk("wrap_ptr", 128'(dut.rr_ptr), 128'(1));

        // oldest taken branch across the ROB wrap
        rob_head = 5'd30;
        fu_packet_in[0].if_take_branch = 1'b1; fu_packet_in[0].rob_entry = 5'd1;  fu_packet_in[0].target_pc = 32'h40;
        fu_packet_in[1].if_take_branch = 1'b1; fu_packet_in[1].rob_entry = 5'd31; fu_packet_in[1].target_pc = 32'h80;
        want_to_complete = 4'b0011; cyc();
        chk("br_valid", 128'(br_recover_valid), 128'(1));
        chk("br_pc", 128'(br_recover_pc), 128'(32'h80));
        chk("br_rob", 128'(br_recover_rob), 128'(31));
        chk("br_lane0", 128'(cdb_packet_out[0].rob_entry), 128'(31));
        want_to_complete = 4'b0000; cyc();
        chk("br_drop", 128'(br_recover_valid), 128'(0));
        chk("br_hold", 128'({br_recover_pc, br_recover_rob}), 128'({32'h80, 5'd31}));

        // squash while an FU is stalled
        set_fus(); want_to_complete = 4'b0111;
        #1 chk("presq_stall", 128'(complete_stall), 128'(4'b0001));
        cyc();
        squash = 1'b1; fu_packet_in[0].if_take_branch = 1'b1; fu_packet_in[0].target_pc = 32'h123;
        #1 chk("sq_stall", 128'(complete_stall), 128'(4'b0000));
        cyc();
        squash = 1'b0;
        chk("sq_l0", 128'(cdb_packet_out[0].valid), 128'(0));
        chk("sq_l1", 128'(cdb_packet_out[1].valid), 128'(0));
        chk("sq_br", 128'(br_recover_valid), 128'(0));
        chk("sq_ptr", 128'(dut.rr_ptr), 128'(3));

        // reset while three FUs request
        set_fus(); want_to_complete = 4'b0111;
        #1 chk("prerst_stall", 128'(complete_stall), 128'(4'b0100));
        reset = 1'b1;
        #1 chk("rst_stall", 128'(complete_stall), 128'(4'b0000));
        cyc();
        reset = 1'b0; want_to_complete = '0;
        chk("rst_l0", 128'(cdb_packet_out[0]), 128'(0));
        chk("rst_l1", 128'(cdb_packet_out[1]), 128'(0));
        chk("rst_br", 128'({br_recover_valid, br_recover_pc, br_recover_rob}), 128'(0));
        chk("rst_ptr", 128'(dut.rr_ptr), 128'(0));

        // vector table, applied in sequence from rr_ptr = 0
        vt[0] = '{4'b0001, 1'b0, 4'b0000, 0, -1, 1};
        vt[1] = '{4'b1111, 1'b0, 4'b1001, 1,  2, 3};
        vt[2] = '{4'b1111, 1'b0, 4'b0110, 3,  0, 1};
        vt[3] = '{4'b0000, 1'b0, 4'b0000, -1, -1, 1};
        vt[4] = '{4'b0001, 1'b0, 4'b0000, 0, -1, 1};
        vt[5] = '{4'b1010, 1'b0, 4'b0000, 1,  3, 0};
        vt[6] = '{4'b1111, 1'b1, 4'b0000, -1, -1, 0};
        vt[7] = '{4'b1110, 1'b0, 4'b1000, 1,  2, 3};
        vt[8] = '{4'b0110, 1'b0, 4'b0000, 1,  2, 3};
        vt[9] = '{4'b0100, 1'b0, 4'b0000, 2, -1, 3};
        set_fus();
        for (int v = 0; v < 10; v++) begin
            want_to_complete = vt[v].req; squash = vt[v].sq;
            #1 chk($sformatf("vec%0d_stall", v), 128'(complete_stall), 128'(vt[v].stall));
            cyc();
            if (vt[v].src0 >= 0) chk($sformatf("vec%0d_l0", v), 128'(cdb_packet_out[0]), 128'(pk(vt[v].src0)));
            else                 chk($sformatf("vec%0d_l0v", v), 128'(cdb_packet_out[0].valid), 128'(0));
            if (vt[v].src1 >= 0) chk($sformatf("vec%0d_l1", v), 128'(cdb_packet_out[1]), 128'(pk(vt[v].src1)));
            else                 chk($sformatf("vec%0d_l1v", v), 128'(cdb_packet_out[1].valid), 128'(0));
            chk($sformatf("vec%0d_br", v), 128'(br_recover_valid), 128'(0));
            chk($sformatf("vec%0d_ptr", v), 128'(dut.rr_ptr), 128'(vt[v].ptr));
        end
        squash = 1'b0;

        // randomized traffic against a queue-based reference model
        do_reset();
        m_ptr = 0; m_pc = '0; m_rob = '0; next_rob = 0; hold = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NF; i++) begin
                if (!hold[i]) begin
                    mp[i]                = '0;
                    mp[i].valid          = ($urandom_range(7) != 0);
                    mp[i].dest_pr        = PRF_IDX_W'($urandom);
                    mp[i].dest_value     = $urandom;
                    mp[i].rob_entry      = ROB_IDX_W'(next_rob);
                    mp[i].if_take_branch = ($urandom_range(2) == 0);
                    mp[i].target_pc      = $urandom;
                    mp[i].halt           = ($urandom_range(7) == 0);
                    next_rob++;
                    w[i] = 1'($urandom_range(1));
                end else begin
                    w[i] = 1'b1;
                end
                fu_packet_in[i] = mp[i];
            end
            sq_r = ($urandom_range(11) == 0);
            rob_head = 5'($urandom);
            want_to_complete = w; squash = sq_r;

            g.delete(); gmask = '0; exp_stall = '0;
            if (!sq_r) begin
                for (int s = 0; s < NF; s++) begin
                    int idx;
                    idx = (m_ptr + s) % NF;
                    if (w[idx] && mp[idx].valid) begin
                        if (g.size() < CW) begin g.push_back(idx); gmask[idx] = 1'b1; end
                        else exp_stall[idx] = 1'b1;
                    end
                end
            end
            best_v = 1'b0; best_age = 0;
            foreach (g[k]) begin
                if (mp[g[k]].if_take_branch) begin
                    a = (int'(mp[g[k]].rob_entry) - int'(rob_head) + 32) % 32;
                    if (!best_v || a < best_age) begin
                        best_v = 1'b1; best_age = a;
                        m_pc = mp[g[k]].target_pc; m_rob = mp[g[k]].rob_entry;
                    end
                end
            end
            if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NF;

            #1 chk("rnd_stall", 128'(complete_stall), 128'(exp_stall));
            cyc();
            for (int k = 0; k < CW; k++) begin
                if (k < g.size()) chk("rnd_lane", 128'(cdb_packet_out[k]), 128'(mp[g[k]]));
                else              chk("rnd_lane_v", 128'(cdb_packet_out[k].valid), 128'(0));
            end
            chk("rnd_br_valid", 128'(br_recover_valid), 128'(best_v));
            chk("rnd_br_pc", 128'(br_recover_pc), 128'(m_pc));
            chk("rnd_br_rob", 128'(br_recover_rob), 128'(m_rob));
            chk("rnd_ptr", 128'(dut.rr_ptr), 128'(m_ptr));
            hold = exp_stall;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
